// File: rtl/oled_arb_pkg.sv
// Shared types and constants for the OLED source arbiter.
package oled_arb_pkg;

    // Arbiter FSM encoding
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_GRANTED = 1'b1
    } arb_state_t;

    localparam int PIXEL_W = 16;
    localparam int OLED_W  = 96;
    localparam int OLED_H  = 64;

    // Colour shown while nobody owns the panel
    localparam logic [PIXEL_W-1:0] BLANK_DEFAULT = 16'h0000;

endpackage

// File: rtl/oled_source_arbiter_rr_picker.sv
// Round-robin picker: finds the first set request after `start`, wrapping.
// With `excl` set, `start` itself is never chosen (rotation to another source).
module rr_picker #(
    parameter int N_SRC = 4,
    parameter int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] start,
    input  logic             excl,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan start+1, start+2, ... start+N_SRC (== start) and keep the first hit
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N_SRC; i++) begin
            int j;
            j = (int'(start) + i) % N_SRC;
            if (!found && req[j] && !(excl && (i == N_SRC))) begin
                found = 1'b1;
                idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/oled_source_arbiter.sv
// Frame-synchronous round-robin arbiter sharing one OLED pixel stream
// between N_SRC renderers, with a minimum per-grant hold in frames.
module oled_source_arbiter
    import oled_arb_pkg::*;
#(
    parameter int                 N_SRC      = 4,
    parameter int                 MIN_FRAMES = 2,
    parameter logic [PIXEL_W-1:0] BLANK      = BLANK_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       frame_begin,
    input  logic [N_SRC-1:0]           req,
    input  logic [PIXEL_W*N_SRC-1:0]   src_pixel,
    output logic [PIXEL_W-1:0]         pixel_data,
    output logic [N_SRC-1:0]           grant,
    output logic                       active,
    output logic                       switch_pulse
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [7:0] MIN_HOLD = 8'(MIN_FRAMES);

    arb_state_t                     state;
    logic [IDX_W-1:0]               cur;
    logic [7:0]                     hold_cnt;
    logic                           fb_q;
    logic                           frame_start;
    logic                           pick_found;
    logic [IDX_W-1:0]               pick_idx;
    logic [N_SRC-1:0]               pick_onehot;
    logic [N_SRC-1:0][PIXEL_W-1:0]  src_arr;

    assign src_arr     = src_pixel;
    assign frame_start = frame_begin & ~fb_q;
    assign pick_onehot = N_SRC'(1) << pick_idx;

    // Edge detector; resets high so a level already high at release is ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) fb_q <= 1'b1;
        else       fb_q <= frame_begin;
    end

    // In IDLE cur may be re-picked (searched last); when GRANTED, rotation
    // always moves to a different source.
    rr_picker #(.N_SRC(N_SRC), .IDX_W(IDX_W)) u_pick (
        .req   (req),
        .start (cur),
        .excl  (state == ST_GRANTED),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Arbitration FSM: decisions only on frame starts, outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cur          <= IDX_W'(N_SRC - 1);
            hold_cnt     <= 8'd0;
            grant        <= '0;
            active       <= 1'b0;
            switch_pulse <= 1'b0;
        end else begin
            switch_pulse <= 1'b0;
            if (frame_start) begin
                case (state)
                    ST_IDLE: begin
                        if (pick_found) begin
                            state        <= ST_GRANTED;
                            cur          <= pick_idx;
                            hold_cnt     <= 8'd1;
                            grant        <= pick_onehot;
                            active       <= 1'b1;
                            switch_pulse <= 1'b1;
                        end
                    end
                    ST_GRANTED: begin
                        if (!req[cur]) begin
                            // Owner walked away: minimum hold does not apply
                            if (pick_found) begin
                                cur      <= pick_idx;
                                hold_cnt <= 8'd1;
                                grant    <= pick_onehot;
                            end else begin
                                state  <= ST_IDLE;
                                grant  <= '0;
                                active <= 1'b0;
                            end
                            switch_pulse <= 1'b1;
                        end else if (hold_cnt < MIN_HOLD) begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end else if (pick_found) begin
                            cur          <= pick_idx;
                            hold_cnt     <= 8'd1;
                            grant        <= pick_onehot;
                            switch_pulse <= 1'b1;
                        end else begin
                            hold_cnt <= MIN_HOLD;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Pixel mux driven from the registered grant: one cycle behind it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pixel_data <= BLANK;
        else       pixel_data <= active ? src_arr[cur] : BLANK;
    end

endmodule

// File: tb/tb_oled_source_arbiter.sv
// Scoreboard bench for oled_source_arbiter: stimulus queues expected
// grant/pixel observations stamped with a cycle number; a negedge monitor
// pops and compares them.
module tb_oled_source_arbiter;

    logic        clk;
    logic        reset;
    logic        frame_begin;
    logic [3:0]  req;
    logic [63:0] src_pixel;
    logic [15:0] pixel_data;
    logic [3:0]  grant;
    logic        active;
    logic        switch_pulse;

    oled_source_arbiter #(.N_SRC(4), .MIN_FRAMES(2), .BLANK(16'h0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_begin  (frame_begin),
        .req          (req),
        .src_pixel    (src_pixel),
        .pixel_data   (pixel_data),
        .grant        (grant),
        .active       (active),
        .switch_pulse (switch_pulse)
    );

    typedef struct {
        int          cyc;
        bit          is_pix;
        logic [3:0]  g;
        logic        sw;
        logic [15:0] pix;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_pulses = 0;
    int   seen_pulses = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, expv);
        end
    endtask

    task automatic push(input int c, input bit is_pix, input logic [3:0] g,
                        input logic sw, input logic [15:0] pix);
        exp_t e;
        e.cyc = c; e.is_pix = is_pix; e.g = g; e.sw = sw; e.pix = pix;
        sb.push_back(e);
    endtask

    // Monitor: compares every queued observation that is due this cycle
    always @(negedge clk) begin
        if (switch_pulse) seen_pulses++;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc != cyc) check("sb_timing", 32'(cyc), 32'(e.cyc));
            else if (e.is_pix) check("pixel_data", 32'(pixel_data), 32'(e.pix));
            else begin
                check("grant",        32'(grant),        32'(e.g));
                check("active",       32'(active),       32'(e.g != 4'b0));
                check("switch_pulse", 32'(switch_pulse), 32'(e.sw));
            end
        end
    end

    // One frame: rising edge, expected grant next cycle, pixel the cycle after
    task automatic frame(input logic [3:0] g, input logic sw, input logic [15:0] pix);
        int k;
        @(posedge clk); #1;
        frame_begin = 1'b1;
        k = cyc;
        push(k + 1, 0, g, sw, 16'h0);
        push(k + 2, 0, g, 1'b0, 16'h0);
        push(k + 2, 1, 4'h0, 1'b0, pix);
        if (sw) exp_pulses++;
        repeat (4) @(posedge clk);
        #1 frame_begin = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    // Expect the grant to stay put (no pulse) for n cycles
    task automatic hold_check(input int n, input logic [3:0] g);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            push(cyc + 1, 0, g, 1'b0, 16'h0);
        end
    endtask

    initial begin
        logic [3:0] pat [3];
        int k;
        pat[0] = 4'b0000; pat[1] = 4'b0001; pat[2] = 4'b0100;
        reset       = 1'b1;
        frame_begin = 1'b0;
        req         = 4'b0000;
        src_pixel   = {16'hFFFF, 16'h001F, 16'h07E0, 16'hF800};

        // Reset state
        repeat (2) @(posedge clk); #1;
        push(cyc + 1, 0, 4'b0000, 1'b0, 16'h0);
        push(cyc + 1, 1, 4'b0000, 1'b0, 16'h0000);
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk);

        // No requests: three frames stay idle and blank
        repeat (3) frame(4'b0000, 1'b0, 16'h0000);

        // Single requester: first grant goes to source 0
        req = 4'b0001;
        frame(4'b0001, 1'b1, 16'hF800);

        // Two requesters, MIN_FRAMES=2 rotation
        req = 4'b0101;
        frame(4'b0001, 1'b0, 16'hF800);
        frame(4'b0100, 1'b1, 16'h001F);
        frame(4'b0100, 1'b0, 16'h001F);
        frame(4'b0001, 1'b1, 16'hF800);
        frame(4'b0001, 1'b0, 16'hF800);
        frame(4'b0100, 1'b1, 16'h001F);   // source 2, hold_cnt = 1

        // Owner drops mid-frame: grant kept until the next frame start,
        // then moves on despite the minimum hold
        @(posedge clk); #1 req = 4'b1000;
        hold_check(3, 4'b0100);
        frame(4'b1000, 1'b1, 16'hFFFF);

        // frame_begin held high 500 cycles while req toggles
        @(posedge clk); #1;
        frame_begin = 1'b1;
        k = cyc;
        push(k + 1, 0, 4'b1000, 1'b0, 16'h0);
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            req = pat[i % 3];
            if (i % 50 == 0) push(cyc + 1, 0, 4'b1000, 1'b0, 16'h0);
        end
        req = 4'b0001;
        frame_begin = 1'b0;
        repeat (3) @(posedge clk);
        frame(4'b0001, 1'b1, 16'hF800);

        // Reset asserted mid-frame while granted
        @(posedge clk); #1;
        frame_begin = 1'b1;
        k = cyc;
        push(k + 1, 0, 4'b0001, 1'b0, 16'h0);
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_rst_grant",  32'(grant),        32'h0);
        check("async_rst_active", 32'(active),       32'h0);
        check("async_rst_pixel",  32'(pixel_data),   32'h0);
        check("async_rst_pulse",  32'(switch_pulse), 32'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        req = 4'b0101;
        hold_check(5, 4'b0000);
        @(posedge clk); #1 frame_begin = 1'b0;
        repeat (3) @(posedge clk);
        frame(4'b0001, 1'b1, 16'hF800);

        // All requests gone: back to idle with a pulse
        req = 4'b0000;
        frame(4'b0000, 1'b1, 16'h0000);

        // Drain scoreboard with a bounded wait
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        @(negedge clk); #1;
        check("sb_drained", 32'(sb.size()), 32'h0);
        check("pulse_count", 32'(seen_pulses), 32'(exp_pulses));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/oled_source_arbiter.md
# oled_source_arbiter

Shares the single 96x64 RGB565 OLED pixel stream between up to `N_SRC` renderers, such as task views or group-ID overlays. Each renderer asserts a request. The block grants exactly one source at a time and switches only at frame boundaries, so no frame ever tears. It uses round-robin rotation with a minimum per-grant hold. It sits between the renderers and the `pixel_data` input of `Oled_Display`, and replaces ad-hoc muxing in the top-level task controller.

## Interface
- `N_SRC`, 4, number of requesting sources (2..8)
- `MIN_FRAMES`, 2, minimum whole frames a grant is held while its source still requests (1..255)
- `BLANK`, 16'h0000, colour driven when no source is granted
- `clk` in 1: system clock; all inputs are synchronous to it
- `reset` in 1: asynchronous, active-high
- `frame_begin` in 1: level from the OLED driver, synchronised to `clk`; its rising edge marks a frame start
- `req` in N_SRC: per-source request level
- `src_pixel` in 16*N_SRC: source i colour in bits [16i+15:16i]
- `pixel_data` out 16: registered selected colour
- `grant` out N_SRC: registered; one-hot, or all-zero when idle
- `active` out 1: high whenever `grant` is non-zero
- `switch_pulse` out 1: one-cycle pulse in the cycle `grant` takes a new value

## Operation
- Frame-start detection:
  - `fb_q` is a register of `frame_begin`.
  - `frame_start = frame_begin & ~fb_q`.
  - `fb_q` resets to 1, so a high `frame_begin` at reset release is not treated as a frame start.
- Arbitration decisions are made only on a clock edge where `frame_start` is true. Between frame starts, `req` changes are ignored.
- States are IDLE and GRANTED. The block also keeps `cur` (index of the granted source) and `hold_cnt` (8 bits).
- IDLE, on `frame_start`:
  - Any `req` set: pick the first set request searching from `cur+1` upward, wrapping modulo N_SRC. Grant it, set `hold_cnt`=1, go to GRANTED.
  - No `req` set: stay in IDLE.
- GRANTED, on `frame_start`, first matching rule applies:
  - `req[cur]`=0: round-robin pick among the other sources. If none is requesting, go to IDLE with `grant`=0. The minimum hold is waived in this case.
  - `hold_cnt` < MIN_FRAMES: keep the grant and increment `hold_cnt`.
  - Another source requesting: rotate to the next requester after `cur` and set `hold_cnt`=1.
  - Otherwise: keep the grant; `hold_cnt` saturates at MIN_FRAMES.
- `cur` keeps its value in IDLE so that rotation resumes fairly.
- Datapath: `pixel_data <= active ? src_pixel[cur] : BLANK` every cycle, using the registered grant.
- Reset values:
  - state IDLE
  - `grant`=0, `active`=0, `switch_pulse`=0
  - `cur`=N_SRC-1, so the first grant goes to source 0 when it is requesting
  - `hold_cnt`=0
  - `pixel_data`=BLANK
- Reset asserted mid-frame: all outputs return to their reset values immediately. The next grant happens at the first frame start after reset is released.

## Timing
- Frame-start to grant:
  - Cycle T: `frame_begin` rises.
  - Edge ending T: `frame_start` is sampled.
  - Cycle T+1: `grant`, `active` and `switch_pulse` are valid.
- Pixel path: 1-cycle latency from `src_pixel` to `pixel_data`.
  - First new-source pixel: the new grant is visible in cycle T+1, so `pixel_data` shows the new source from cycle T+2.
  - OLED sampling happens on the 6.25 MHz clock, well after this, so no tearing occurs.
- `switch_pulse` fires on IDLE->GRANTED, on a rotation, and on GRANTED->IDLE. It does not fire when the grant is kept.
- `frame_begin` held high for many cycles produces exactly one `frame_start`.

## Structure
- Package `oled_arb_pkg`:
  - state encoding (IDLE, GRANTED)
  - `PIXEL_W`=16, `OLED_W`=96, `OLED_H`=64
  - default `BLANK` colour
- Sub-module `rr_picker`:
  - combinational; inputs are the request vector, the start index and an exclude-current flag
  - outputs are `found` and `idx`
  - used for both the IDLE pick and the GRANTED rotation

## Test plan
- Reset with `req`=0, then 3 frame starts → `grant`=0, `pixel_data`=16'h0000 throughout, no `switch_pulse`.
- `req`=4'b0001, `src_pixel[0]`=16'hF800 → `grant`=0001 one cycle after the first `frame_begin` rise, `pixel_data`=16'hF800 one cycle later, a single `switch_pulse`.
- `req`=4'b0101 held, MIN_FRAMES=2 → grant sequence per frame start is 0001, 0001, 0100, 0100, 0001.
- Source 2 granted with `hold_cnt`=1, `req[2]` drops mid-frame, `req[3]`=1 → grant stays 0100 until the next frame start, then changes to 1000 despite the minimum hold.
- `req` toggles during a frame while `frame_begin` stays high for 500 cycles → no grant change until the next rising edge.
- Reset asserted mid-frame while granted → `grant`=0 and `pixel_data`=BLANK asynchronously. After release with `frame_begin` already high, no grant until the next rising edge; then source 0 is picked first.
